addition_control_unit: RTL and testbench

//  Sequencer for the single-precision FP adder datapath (stages 1-4).

---
 rtl/fp_add_pkg.sv | 32 +++
 rtl/fp_align_counter.sv | 26 ++
 rtl/addition_control_unit.sv | 133 +++++++++++++
 tb/tb_addition_control_unit.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/fp_add_pkg.sv
// Shared types and constants for the FP adder sequencer.
// Holds the state encoding, datapath widths and the alignment-amount helper.
package fp_add_pkg;

    localparam int EXPO_WIDTH      = 8;
    localparam int MENT_WIDTH      = 23;
    localparam int SHIFT_MAX       = MENT_WIDTH + 1;
    localparam int NORM_MAX_CYCLES = MENT_WIDTH + 2;
    localparam int SHIFT_W         = $clog2(SHIFT_MAX + 1);
    localparam int NORM_W          = $clog2(NORM_MAX_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        ALIGN,
        ADD,
        NORM,
        DONE
    } state_t;

    // |exp_diff| clamped to SHIFT_MAX; larger shifts clear the operand anyway
    function automatic logic [SHIFT_W-1:0] align_amount(
        input logic [EXPO_WIDTH:0] diff
    );
        logic [EXPO_WIDTH:0] mag;
        mag = diff[EXPO_WIDTH] ? (~diff + (EXPO_WIDTH+1)'(1)) : diff;
        if (mag > (EXPO_WIDTH+1)'(SHIFT_MAX))
            return SHIFT_W'(SHIFT_MAX);
        return mag[SHIFT_W-1:0];
    endfunction

endpackage

// File: rtl/fp_align_counter.sv
// Loadable down-counter that sticks at zero; meters alignment shifts.
// Ports: clk, rst_n, load, dec, load_val in; cnt, zero out.
module fp_align_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt,
    output logic         zero
);

    assign zero = (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && !zero)
            cnt <= cnt - W'(1);
    end

endmodule

// File: rtl/addition_control_unit.sv
// Sequencer for the FP adder: compare, align, add, normalise, done.
// In: clk_in, rst_n_in, start_in, exp_diff_in, norm_done_in; out: selects, enables, status.
module addition_control_unit
    import fp_add_pkg::*;
(
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic                start_in,
    input  logic [EXPO_WIDTH:0] exp_diff_in,
    input  logic                norm_done_in,
    output logic                mux1_sel_out,
    output logic                mux2_sel_out,
    output logic                mux3_sel_out,
    output logic                load_en_out,
    output logic                align_shift_out,
    output logic                add_en_out,
    output logic                norm_en_out,
    output logic                busy_out,
    output logic                done_out,
    output logic                norm_err_out
);

    state_t              state;
    state_t              next_state;
    logic                sel_q;
    logic [NORM_W-1:0]   norm_cnt;
    logic                norm_done_q;
    logic                norm_err_q;
    logic                shift_load;
    logic                shift_dec;
    logic [SHIFT_W-1:0]  shift_amt;
    logic [SHIFT_W-1:0]  shift_cnt;
    logic                shift_zero;
    logic                norm_en;
    logic                norm_timeout;
    logic                accept;
    logic                err_set;

    assign shift_amt    = align_amount(exp_diff_in);
    assign accept       = (state == IDLE) && start_in;
    assign norm_timeout = (norm_cnt == NORM_W'(NORM_MAX_CYCLES));
    // stop stepping once stage 4 has reported done or the budget is spent
    assign norm_en      = (state == NORM) && !norm_done_q && !norm_timeout;
    assign err_set      = (state == NORM) && !norm_done_q && norm_timeout;

    fp_align_counter #(.W(SHIFT_W)) u_shift_cnt (
        .clk      (clk_in),
        .rst_n    (rst_n_in),
        .load     (shift_load),
        .dec      (shift_dec),
        .load_val (shift_amt),
        .cnt      (shift_cnt),
        .zero     (shift_zero)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        shift_load = 1'b0;
        shift_dec  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_in)
                    next_state = COMPARE;
            end
            COMPARE: begin
                shift_load = 1'b1;
                next_state = (shift_amt == '0) ? ADD : ALIGN;
            end
            ALIGN: begin
                shift_dec = 1'b1;
                // leave on the final pulse so exactly shift_amt pulses are issued
                if (shift_zero || shift_cnt == SHIFT_W'(1))
                    next_state = ADD;
            end
            ADD: begin
                next_state = NORM;
            end
            NORM: begin
                if (norm_done_q || norm_timeout)
                    next_state = DONE;
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // norm_done_in is registered so no output depends on it combinationally
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sel_q       <= 1'b1;
            norm_cnt    <= '0;
            norm_done_q <= 1'b0;
            norm_err_q  <= 1'b0;
        end else begin
            if (state == COMPARE)
                sel_q <= ~exp_diff_in[EXPO_WIDTH];
            if (state != NORM) begin
                norm_cnt    <= '0;
                norm_done_q <= 1'b0;
            end else if (norm_en) begin
                norm_cnt    <= norm_cnt + NORM_W'(1);
                norm_done_q <= norm_done_in;
            end
            if (accept)
                norm_err_q <= 1'b0;
            else if (err_set)
                norm_err_q <= 1'b1;
        end
    end

    assign mux1_sel_out    = sel_q;
    assign mux2_sel_out    = sel_q;
    assign mux3_sel_out    = sel_q;
    assign load_en_out     = (state == COMPARE);
    assign align_shift_out = (state == ALIGN);
    assign add_en_out      = (state == ADD);
    assign norm_en_out     = norm_en;
    assign busy_out        = (state != IDLE);
    assign done_out        = (state == DONE);
    assign norm_err_out    = norm_err_q;

endmodule

// File: tb/tb_addition_control_unit.sv
// Directed scoreboard bench for addition_control_unit.
// Drives additions, counts output pulses per cycle and checks against a model.
module tb_addition_control_unit;

    logic       clk_in = 1'b0;
    logic       rst_n_in;
    logic       start_in;
    logic [8:0] exp_diff_in;
    logic       norm_done_in;
    logic       mux1_sel_out;
    logic       mux2_sel_out;
    logic       mux3_sel_out;
    logic       load_en_out;
    logic       align_shift_out;
    logic       add_en_out;
    logic       norm_en_out;
    logic       busy_out;
    logic       done_out;
    logic       norm_err_out;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int sel;
        int s;
        int n;
        int lat;
        int err;
    } exp_t;

    exp_t sb[$];

    always #5 clk_in = ~clk_in;

    addition_control_unit dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .start_in        (start_in),
        .exp_diff_in     (exp_diff_in),
        .norm_done_in    (norm_done_in),
        .mux1_sel_out    (mux1_sel_out),
        .mux2_sel_out    (mux2_sel_out),
        .mux3_sel_out    (mux3_sel_out),
        .load_en_out     (load_en_out),
        .align_shift_out (align_shift_out),
        .add_en_out      (add_en_out),
        .norm_en_out     (norm_en_out),
        .busy_out        (busy_out),
        .done_out        (done_out),
        .norm_err_out    (norm_err_out)
    );

    task automatic check(input string tag, input int obs, input int expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int sels();
        return int'({mux1_sel_out, mux2_sel_out, mux3_sel_out});
    endfunction

    function automatic int strobes();
        return int'({load_en_out, align_shift_out, add_en_out,
                     norm_en_out, busy_out, done_out, norm_err_out});
    endfunction

    function automatic exp_t model(input logic [8:0] d, input int done_at);
        exp_t e;
        int sv;
        int mag;
        sv     = d[8] ? int'(d) - 512 : int'(d);
        mag    = (sv < 0) ? -sv : sv;
        e.sel  = (sv >= 0) ? 7 : 0;
        e.s    = (mag > 24) ? 24 : mag;
        e.n    = (done_at == 0) ? 25 : done_at;
        e.lat  = 4 + e.s + e.n;
        e.err  = (done_at == 0) ? 1 : 0;
        return e;
    endfunction

    // done_at: norm_en cycle in which stage 4 reports done (0 = never)
    // spur_at: align pulse count after which a stray start is pulsed (0 = none)
    task automatic run_op(input logic [8:0] d, input int done_at,
                          input int spur_at);
        exp_t e;
        int cyc, cnt_s, cnt_n, add_cyc, load_cyc, done_cyc;
        int err_start, err_done, sel_done;
        bit got;
        sb.push_back(model(d, done_at));
        cnt_s = 0; cnt_n = 0; add_cyc = -1; load_cyc = -1;
        done_cyc = -1; err_start = -1; err_done = -1; sel_done = -1;
        got = 1'b0;
        @(negedge clk_in);
        exp_diff_in = d;
        start_in = 1'b1;
        @(negedge clk_in);
        cyc = 1;
        while (cyc <= 100 && !got) begin
            start_in = 1'b0;
            if (cyc == 1) err_start = int'(norm_err_out);
            if (load_en_out) load_cyc = cyc;
            if (add_en_out) add_cyc = cyc;
            if (align_shift_out) begin
                cnt_s++;
                if (cnt_s == spur_at) start_in = 1'b1;
            end
            if (norm_en_out) begin
                cnt_n++;
                if (cnt_n == done_at) norm_done_in = 1'b1;
            end
            if (done_out) begin
                got = 1'b1;
                done_cyc = cyc;
                err_done = int'(norm_err_out);
                sel_done = sels();
                norm_done_in = 1'b0;
            end else begin
                @(negedge clk_in);
                cyc++;
            end
        end
        start_in = 1'b0;
        norm_done_in = 1'b0;
        check("done_seen", int'(got), 1);
        e = sb.pop_front();
        check("sel", sel_done, e.sel);
        check("load_cycle", load_cyc, 1);
        check("err_clr_start", err_start, 0);
        check("align_pulses", cnt_s, e.s);
        check("add_cycle", add_cyc, 2 + e.s);
        check("norm_cycles", cnt_n, e.n);
        check("latency", done_cyc, e.lat);
        check("norm_err", err_done, e.err);
        @(negedge clk_in);
        check("idle_after", int'({busy_out, done_out}), 0);
    endtask

    initial begin
        int dones;
        rst_n_in = 1'b0;
        start_in = 1'b0;
        exp_diff_in = '0;
        norm_done_in = 1'b0;
        repeat (2) @(negedge clk_in);
        check("reset_sel", sels(), 7);
        check("reset_strobes", strobes(), 0);
        rst_n_in = 1'b1;
        @(negedge clk_in);

        run_op(9'h003, 2, 0);
        run_op(9'h1FD, 1, 0);
        run_op(9'h000, 1, 0);
        run_op(9'h0C8, 3, 0);
        run_op(9'h005, 0, 0);
        check("err_sticky", int'(norm_err_out), 1);
        run_op(9'h1F0, 1, 0);
        run_op(9'h00A, 2, 4);

        // reset in the middle of ALIGN
        @(negedge clk_in);
        exp_diff_in = 9'h1F6;
        start_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
        repeat (3) @(negedge clk_in);
        check("mid_align", int'(align_shift_out), 1);
        check("mid_sel", sels(), 0);
        rst_n_in = 1'b0;
        #1;
        check("abort_sel", sels(), 7);
        check("abort_strobes", strobes(), 0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        dones = 0;
        repeat (30) begin
            @(negedge clk_in);
            if (done_out || busy_out) dones++;
        end
        check("no_done_after_abort", dones, 0);

        run_op(9'h002, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
